// File: rtl/out_mem_pkg.sv
// Shared types for the accumulate memory: clear FSM states and the
// accumulate pipeline stage records (fields sized for the widest supported bank).
package out_mem_pkg;

  localparam int MAX_ADDR_W = 16;
  localparam int MAX_DATA_W = 64;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } clr_state_e;

  // S0: accumulate accepted this cycle, old value being read from storage.
  typedef struct packed {
    logic                  valid;
    logic [MAX_ADDR_W-1:0] addr;
    logic [MAX_DATA_W-1:0] data;
  } acc_s0_t;

  // S1: add and commit; fwd selects the previous S1 sum instead of storage.
  typedef struct packed {
    logic                  valid;
    logic                  fwd;
    logic [MAX_ADDR_W-1:0] addr;
    logic [MAX_DATA_W-1:0] data;
  } acc_s1_t;

endpackage

// File: rtl/out_acc_bank.sv
// One bank: storage, read port, overwrite and 2-stage accumulate with forwarding.
// Saturating accumulate and the sticky acc_ovf flag exist only under OUT_ACC_MEM_SAT_EN.
module out_acc_bank
  import out_mem_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 256,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  busy,
  input  logic                  clr_we,
  input  logic [ADDR_WIDTH-1:0] clr_addr,
`ifdef OUT_ACC_MEM_SAT_EN
  input  logic                  clr_ovf,
  output logic                  acc_ovf,
`endif
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_ready,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic                  wr_acc,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  acc_s0_t               s0;
  acc_s1_t               s1_q;
  logic [DATA_WIDTH-1:0] old_q, last_sum_q, old_val, addend, sum_val;
  logic [ADDR_WIDTH-1:0] s1_addr;
  logic                  wr_go, ow_go, rd_go, s1_commit;

  assign wr_ready = ~busy;
  // The S0 old-value read owns the storage read port this cycle.
  assign rd_ready = ~busy & ~(wr_en & wr_acc);
  assign wr_go    = wr_en & ~busy;
  assign ow_go    = wr_go & ~wr_acc;
  assign rd_go    = rd_en & rd_ready;

  always_comb begin
    s0       = '0;
    s0.valid = wr_go & wr_acc;
    s0.addr  = MAX_ADDR_W'(wr_addr);
    s0.data  = MAX_DATA_W'(wr_data);
  end

  assign s1_addr   = s1_q.addr[ADDR_WIDTH-1:0];
  assign addend    = s1_q.data[DATA_WIDTH-1:0];
  assign old_val   = s1_q.fwd ? last_sum_q : old_q;
  // A same-address overwrite arriving during S1 is the later request and wins.
  assign s1_commit = s1_q.valid & rstn & ~(ow_go & (wr_addr == s1_addr));

`ifdef OUT_ACC_MEM_SAT_EN
  logic ovf;
`endif

  always_comb begin
    sum_val = old_val + addend;
`ifdef OUT_ACC_MEM_SAT_EN
    ovf = (old_val[DATA_WIDTH-1] == addend[DATA_WIDTH-1]) &&
          (sum_val[DATA_WIDTH-1] != old_val[DATA_WIDTH-1]);
    if (ovf) begin
      sum_val = old_val[DATA_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                      : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_q     <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      s1_q.valid <= s0.valid;
      s1_q.addr  <= s0.addr;
      s1_q.data  <= s0.data;
      s1_q.fwd   <= s0.valid & s1_q.valid & (s1_q.addr == s0.addr);
      rd_valid   <= rd_go;
      if (rd_go) rd_data <= mem[rd_addr];
    end
  end

  // NOTE: storage and datapath holding registers are deliberately not reset;
  // only control state is, which keeps the array mappable to RAM.
  always_ff @(posedge clk) begin
    if (s0.valid) old_q <= mem[wr_addr];
    last_sum_q <= sum_val;
    if (s1_commit) mem[s1_addr] <= sum_val;
    if (ow_go) mem[wr_addr] <= wr_data;
    if (clr_we) mem[clr_addr] <= '0;
  end

`ifdef OUT_ACC_MEM_SAT_EN
  always_ff @(posedge clk) begin
    if (!rstn || clr_ovf) acc_ovf <= 1'b0;
    else if (s1_commit && ovf) acc_ovf <= 1'b1;
  end
`endif

endmodule

// File: rtl/out_acc_mem.sv
// Multi-bank accumulate memory with a shared zeroing FSM.
// Define OUT_ACC_MEM_SAT_EN for saturating accumulate and the acc_ovf output.
module out_acc_mem
  import out_mem_pkg::*;
#(
  parameter  int NUM_BANK   = 16,
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 256,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic                                 clr_start,
  output logic                                 busy,
  input  logic [NUM_BANK-1:0]                  rd_en,
  input  logic [NUM_BANK-1:0][ADDR_WIDTH-1:0]  rd_addr,
  output logic [NUM_BANK-1:0]                  rd_ready,
  output logic [NUM_BANK-1:0]                  rd_valid,
  output logic [NUM_BANK-1:0][DATA_WIDTH-1:0]  rd_data,
  input  logic [NUM_BANK-1:0]                  wr_en,
  input  logic [NUM_BANK-1:0]                  wr_acc,
  input  logic [NUM_BANK-1:0][ADDR_WIDTH-1:0]  wr_addr,
  input  logic [NUM_BANK-1:0][DATA_WIDTH-1:0]  wr_data,
  output logic [NUM_BANK-1:0]                  wr_ready
`ifdef OUT_ACC_MEM_SAT_EN
  ,
  output logic [NUM_BANK-1:0]                  acc_ovf
`endif
);

  clr_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  clr_we;

  // The clr_start cycle already writes address 0: no accumulate can be in S0
  // then (wr_ready is low) and a final S1 commit is overridden by the clear write.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    busy    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clr_start && rstn) begin
          busy    = 1'b1;
          clr_we  = 1'b1;
          state_d = ST_CLEAR;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      ST_CLEAR: begin
        busy   = 1'b1;
        clr_we = rstn;
        if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of statement order.
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef OUT_ACC_MEM_SAT_EN
  logic clr_ovf;
  assign clr_ovf = clr_start & (state_q == ST_IDLE);
`endif

  for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
    out_acc_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
    ) u_bank (
      .clk      (clk),
      .rstn     (rstn),
      .busy     (busy),
      .clr_we   (clr_we),
      .clr_addr (cnt_q),
`ifdef OUT_ACC_MEM_SAT_EN
      .clr_ovf  (clr_ovf),
      .acc_ovf  (acc_ovf[b]),
`endif
      .rd_en    (rd_en[b]),
      .rd_addr  (rd_addr[b]),
      .rd_ready (rd_ready[b]),
      .rd_valid (rd_valid[b]),
      .rd_data  (rd_data[b]),
      .wr_en    (wr_en[b]),
      .wr_acc   (wr_acc[b]),
      .wr_addr  (wr_addr[b]),
      .wr_data  (wr_data[b]),
      .wr_ready (wr_ready[b])
    );
  end

endmodule

// File: tb/tb_out_acc_mem.sv
// Directed bench for out_acc_mem: vector table plus hand-written multi-cycle sequences.
module tb_out_acc_mem;

  localparam int NB = 16;
  localparam int DW = 32;
  localparam int DEPTH = 256;
  localparam int AW = 8;

`ifdef OUT_ACC_MEM_SAT_EN
  localparam logic [DW-1:0] OVF_EXP = 32'h7FFF_FFFF;
`else
  localparam logic [DW-1:0] OVF_EXP = 32'h8000_0000;
`endif

  logic                   clk = 1'b0;
  logic                   rstn, clr_start, busy;
  logic [NB-1:0]          rd_en, rd_ready, rd_valid, wr_en, wr_acc, wr_ready;
  logic [NB-1:0][AW-1:0]  rd_addr, wr_addr;
  logic [NB-1:0][DW-1:0]  rd_data, wr_data;
`ifdef OUT_ACC_MEM_SAT_EN
  logic [NB-1:0]          acc_ovf;
`endif

  int total = 0;
  int bad   = 0;

  out_acc_mem #(.NUM_BANK(NB), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .clr_start (clr_start),
    .busy      (busy),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_ready  (rd_ready),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .wr_en     (wr_en),
    .wr_acc    (wr_acc),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready)
`ifdef OUT_ACC_MEM_SAT_EN
    ,
    .acc_ovf   (acc_ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int             bank;
    logic           is_wr;
    logic           acc;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  data;
    logic [DW-1:0]  exp;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_en = '0; wr_en = '0; wr_acc = '0;
    rd_addr = '0; wr_addr = '0; wr_data = '0;
  endtask

  task automatic do_wr(input int b, input logic acc, input logic [AW-1:0] a, input logic [DW-1:0] d);
    idle();
    wr_en[b] = 1'b1; wr_acc[b] = acc; wr_addr[b] = a; wr_data[b] = d;
    tick();
  endtask

  task automatic read_chk(input string name, input int b, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    idle();
    rd_en[b] = 1'b1; rd_addr[b] = a;
    tick();
    idle();
    check({name, "_valid"}, 64'(rd_valid[b]), 64'(1));
    check({name, "_data"}, 64'(rd_data[b]), 64'(exp));
  endtask

  function automatic vec_t mk(int b, logic w, logic acc, logic [AW-1:0] a, logic [DW-1:0] d, logic [DW-1:0] e);
    vec_t v;
    v.bank = b; v.is_wr = w; v.acc = acc; v.addr = a; v.data = d; v.exp = e;
    return v;
  endfunction

  initial begin
    int n;
    vecs[0]  = mk(3,  1, 0, 8'd5,   32'h10,        '0);
    vecs[1]  = mk(3,  0, 0, 8'd5,   '0,            32'h10);
    vecs[2]  = mk(2,  0, 0, 8'd5,   '0,            32'h0);
    vecs[3]  = mk(3,  1, 1, 8'd5,   32'h5,         '0);
    vecs[4]  = mk(3,  0, 0, 8'd5,   '0,            32'h15);
    vecs[5]  = mk(3,  1, 1, 8'd5,   32'hFFFF_FFFF, '0);
    vecs[6]  = mk(3,  0, 0, 8'd5,   '0,            32'h14);
    vecs[7]  = mk(15, 1, 0, 8'd255, 32'hDEAD_BEEF, '0);
    vecs[8]  = mk(15, 0, 0, 8'd255, '0,            32'hDEAD_BEEF);
    vecs[9]  = mk(15, 1, 1, 8'd255, 32'h2152_4111, '0);
    vecs[10] = mk(15, 0, 0, 8'd255, '0,            32'h0);
    vecs[11] = mk(0,  1, 0, 8'd0,   32'h7FFF_FFFF, '0);
    vecs[12] = mk(0,  1, 1, 8'd0,   32'h1,         '0);
    vecs[13] = mk(0,  0, 0, 8'd0,   '0,            OVF_EXP);
    vecs[14] = mk(0,  0, 0, 8'd255, '0,            32'h0);

    rstn = 1'b0; clr_start = 1'b0; idle();
    repeat (3) tick();
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_rd_valid", 64'(rd_valid), 64'(0));
    check("rst_rd_data3", 64'(rd_data[3]), 64'(0));
    rstn = 1'b1;
    tick();
    check("idle_wr_ready", 64'(wr_ready), 64'(16'hFFFF));
    check("idle_rd_ready", 64'(rd_ready), 64'(16'hFFFF));

    // Full clear; a second clr_start mid-clear must be ignored.
    clr_start = 1'b1;
    #1;
    check("clr_busy_start", 64'(busy), 64'(1));
    check("clr_rd_ready", 64'(rd_ready), 64'(0));
    check("clr_wr_ready", 64'(wr_ready), 64'(0));
    n = 0;
    while (busy && n < 400) begin
      n++;
      tick();
      clr_start = (n == 100);
      #1;
    end
    clr_start = 1'b0;
    check("clr_busy_cycles", 64'(n), 64'(DEPTH));
    for (int a = 0; a < DEPTH; a++) begin
      rd_en = '1;
      for (int b = 0; b < NB; b++) rd_addr[b] = AW'(a);
      tick();
      check("clr_all_zero", 64'(rd_valid == '1 && rd_data == '0), 64'(1));
    end
    idle();
    tick();

    // Single-op vectors; each write gets an idle cycle so accumulates commit.
    for (int i = 0; i < 15; i++) begin
      if (vecs[i].is_wr) begin
        do_wr(vecs[i].bank, vecs[i].acc, vecs[i].addr, vecs[i].data);
        idle();
        tick();
      end else begin
        read_chk($sformatf("vec%0d", i), vecs[i].bank, vecs[i].addr, vecs[i].exp);
      end
    end
`ifdef OUT_ACC_MEM_SAT_EN
    check("ovf_bank0", 64'(acc_ovf[0]), 64'(1));
    check("ovf_bank15", 64'(acc_ovf[15]), 64'(0));
`endif

    // Four back-to-back accumulates to the same address.
    idle();
    for (int k = 0; k < 4; k++) begin
      wr_en[0] = 1'b1; wr_acc[0] = 1'b1; wr_addr[0] = 8'd7; wr_data[0] = 32'd1;
      tick();
    end
    idle();
    tick();
    read_chk("b2b_acc", 0, 8'd7, 32'd4);
    read_chk("b2b_other_bank", 1, 8'd7, 32'd0);

    // Accumulate blocks a same-bank read; the retried read sees pre-commit data.
    idle();
    wr_en[4] = 1'b1; wr_acc[4] = 1'b1; wr_addr[4] = 8'd9; wr_data[4] = 32'd3;
    rd_en[4] = 1'b1; rd_addr[4] = 8'd9;
    rd_en[5] = 1'b1; rd_addr[5] = 8'd9;
    #1;
    check("acc_blocks_rd_ready", 64'(rd_ready[4]), 64'(0));
    check("other_bank_rd_ready", 64'(rd_ready[5]), 64'(1));
    tick();
    check("blocked_no_valid", 64'(rd_valid[4]), 64'(0));
    check("other_bank_valid", 64'(rd_valid[5]), 64'(1));
    wr_en = '0; rd_en[5] = 1'b0;
    #1;
    check("retry_rd_ready", 64'(rd_ready[4]), 64'(1));
    tick();
    check("read_first_valid", 64'(rd_valid[4]), 64'(1));
    check("read_first_data", 64'(rd_data[4]), 64'(0));
    read_chk("acc_visible", 4, 8'd9, 32'd3);

    // Overwrite during S1 of an accumulate: same address overwrite wins.
    do_wr(6, 1'b1, 8'd2, 32'd5);
    do_wr(6, 1'b0, 8'd2, 32'h40);
    do_wr(6, 1'b1, 8'd3, 32'd7);
    do_wr(6, 1'b0, 8'd4, 32'h11);
    idle();
    tick();
    read_chk("ow_wins", 6, 8'd2, 32'h40);
    read_chk("acc_beside_ow", 6, 8'd3, 32'd7);
    read_chk("ow_beside_acc", 6, 8'd4, 32'h11);

    // Reset in the middle of a clear aborts it after addresses 0..2.
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    tick();
    tick();
    check("mid_clear_busy", 64'(busy), 64'(1));
    rstn = 1'b0;
    tick();
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_rd_valid", 64'(rd_valid), 64'(0));
    rstn = 1'b1;
    rd_en[0] = 1'b1; rd_addr[0] = 8'd0;
    #1;
    check("post_rst_rd_ready", 64'(rd_ready[0]), 64'(1));
    read_chk("partial_clear_addr0", 0, 8'd0, 32'd0);
    read_chk("uncleared_addr7", 0, 8'd7, 32'd4);
    read_chk("uncleared_addr3", 6, 8'd3, 32'd7);
`ifdef OUT_ACC_MEM_SAT_EN
    check("ovf_cleared", 64'(acc_ovf[0]), 64'(0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
